qsys_system_nios2_qsys_0_oci_dct_packer: RTL and testbench
==========================================================

QSYS_SYSTEM_NIOS2_QSYS_0_OCI_DCT_PACKER -- requirements
Module: qsys_system_nios2_qsys_0_oci_dct_packer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: port clk (input, 1) is the clock, and port reset (input, 1) is the synchronous active-high reset.
REQ-002 Port atom_valid (input, 1) SHALL indicate a 2-bit compressed trace atom is offered.
REQ-003 Port atom (input, 2) SHALL be the trace atom code.
REQ-004 Port atom_ready (output, 1) SHALL indicate the packer accepts the atom this cycle.
REQ-005 Port flush (input, 1) SHALL be a single-cycle request to emit a partial frame.
REQ-006 Port end_req (input, 1) SHALL be a single-cycle request to finish tracing.
REQ-007 Port dct_buffer (output, 30) SHALL be the packed frame: 15 atom slots, newest atom in [1:0].
REQ-008 Port dct_count (output, 4) SHALL be the number of valid atoms in dct_buffer, range 0..15.
REQ-009 Port frame_valid (output, 1) SHALL indicate dct_buffer/dct_count hold a frame for downstream.
REQ-010 Port frame_ready (input, 1) SHALL be the downstream acceptance of the frame.
REQ-011 Port test_ending (output, 1) SHALL indicate end of trace has been requested and is draining.
REQ-012 Port test_has_ended (output, 1) SHALL indicate the final frame has been consumed.

Function
REQ-013 The state machine SHALL have states FILL, HOLD and ENDED, plus a sticky end_pending flag.
REQ-014 In FILL, atom_ready SHALL be 1; in HOLD and ENDED, atom_ready SHALL be 0.
REQ-015 In FILL, on atom_valid, the block SHALL perform dct_buffer <= {dct_buffer[27:0], atom} and dct_count <= dct_count+1 on the next edge.
REQ-016 When an accept makes dct_count 15, the next state SHALL be HOLD, with frame_valid=1 from the following cycle.
REQ-017 On flush in FILL with dct_count>0 (after counting a same-cycle accepted atom), the block SHALL go to HOLD; the same-cycle atom is included in the frame.
REQ-018 Flush with dct_count=0 and no same-cycle atom SHALL be ignored; flush in HOLD or ENDED SHALL be ignored.
REQ-019 In HOLD, frame_valid SHALL be 1, and dct_buffer and dct_count SHALL be stable until frame_ready.
REQ-020 On frame_valid&frame_ready, dct_buffer SHALL clear to 0 and dct_count SHALL clear to 0 next cycle; the next state SHALL be FILL, or ENDED if end_pending.
REQ-021 frame_valid SHALL be 0 in FILL and ENDED; frame_valid SHALL never assert with dct_count=0.
REQ-022 end_req SHALL set end_pending; test_ending SHALL be 1 from the cycle after end_req until reset.
REQ-023 end_req in FILL with count>0 (including a same-cycle atom) SHALL act as flush, and the final frame SHALL be emitted before ENDED.
REQ-024 end_req in FILL with count=0 SHALL go directly to ENDED next cycle.
REQ-025 end_req in HOLD SHALL set end_pending; the current frame SHALL complete, then the block SHALL go to ENDED.
REQ-026 test_has_ended SHALL be 1 exactly when in ENDED; ENDED SHALL be exited only by reset; end_req SHALL be ignored in ENDED.
REQ-027 The block SHALL have no atom loss: atoms are accepted only with atom_ready=1, and upstream holds an atom while atom_ready=0.

Reset
REQ-028 On reset=1 at a clk edge, the block SHALL enter FILL with dct_buffer=0, dct_count=0, frame_valid=0, atom_ready=1 (from the next cycle), test_ending=0, test_has_ended=0, end_pending=0.
REQ-029 Reset SHALL take priority over all inputs, including mid-frame in HOLD; a pending frame is discarded.

Verification
REQ-030 Fill: the bench SHALL drive 15 consecutive atoms 2'b01 with frame_ready=0 -> frame_valid=1, dct_count=15, dct_buffer=30'h15555555, atom_ready=0 held; with frame_ready=1 -> count=0, FILL.
REQ-031 Partial flush: the bench SHALL drive atoms 3,2,1 then flush -> dct_count=3, dct_buffer=30'h39; flush with count 0 -> no frame_valid.
REQ-032 Simultaneous: the bench SHALL drive atom 2'b11 together with flush at count=4 -> frame dct_count=5, dct_buffer[1:0]=2'b11.
REQ-033 End during HOLD: with a full frame held, the bench SHALL pulse end_req -> test_ending=1 next cycle, test_has_ended=0 until frame_ready, then 1 permanently; atom_ready stays 0.
REQ-034 Empty end: the bench SHALL pulse end_req at count=0 -> ENDED next cycle, frame_valid never 1.
REQ-035 Reset in HOLD: the bench SHALL assert reset with frame_valid=1 -> all outputs at reset values next cycle, and trace resumes normally.

Source files
------------

// File: rtl/qsys_system_nios2_qsys_0_oci_dct_packer_if.sv
// Trace atom / frame handshake bundle for the DCT packer.
// slave: the packer side, master: the atom source and frame sink.
interface qsys_system_nios2_qsys_0_oci_dct_packer_if;
  logic        atom_valid;
  logic [1:0]  atom;
  logic        atom_ready;
  logic        flush;
  logic        end_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic        frame_ready;
  logic        test_ending;
  logic        test_has_ended;

  modport slave (
    input  atom_valid,
    input  atom,
    output atom_ready,
    input  flush,
    input  end_req,
    output dct_buffer,
    output dct_count,
    output frame_valid,
    input  frame_ready,
    output test_ending,
    output test_has_ended
  );

  modport master (
    output atom_valid,
    output atom,
    input  atom_ready,
    output flush,
    output end_req,
    input  dct_buffer,
    input  dct_count,
    input  frame_valid,
    output frame_ready,
    input  test_ending,
    input  test_has_ended
  );
endinterface

// File: rtl/qsys_system_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot frames (newest in [1:0]).
// Ports: clk, reset (sync, active high), bus (atom in, frame out, end).
module qsys_system_nios2_qsys_0_oci_dct_packer (
  input logic clk,
  input logic reset,
  qsys_system_nios2_qsys_0_oci_dct_packer_if.slave bus
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    ENDED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [29:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        endp_q, endp_d;

  logic        accept;
  logic [29:0] buf_acc;
  logic [3:0]  cnt_acc;
  logic        close;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      endp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      endp_q  <= endp_d;
    end
  end

  // Flush/end see the count including a same-cycle atom.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    endp_d  = endp_q | bus.end_req;
    accept  = (state_q == FILL) & bus.atom_valid;
    buf_acc = accept ? {buf_q[27:0], bus.atom} : buf_q;
    cnt_acc = cnt_q + {3'b000, accept};
    close   = bus.flush | bus.end_req;
    unique case (state_q)
      FILL: begin
        buf_d = buf_acc;
        cnt_d = cnt_acc;
        if (accept && cnt_acc == 4'd15)
          state_d = HOLD;
        else if (close && cnt_acc != 4'd0)
          state_d = HOLD;
        else if (bus.end_req)
          state_d = ENDED;
      end
      HOLD: begin
        if (bus.frame_ready) begin
          buf_d = '0;
          cnt_d = '0;
          // A same-cycle end_req must not strand us in FILL.
          state_d = (endp_q | bus.end_req)
                  ? ENDED : FILL;
        end
      end
      ENDED: begin
        state_d = ENDED;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  assign bus.atom_ready     = (state_q == FILL);
  assign bus.frame_valid    = (state_q == HOLD);
  assign bus.dct_buffer     = buf_q;
  assign bus.dct_count      = cnt_q;
  assign bus.test_ending    = endp_q;
  assign bus.test_has_ended = (state_q == ENDED);

endmodule

// File: tb/tb_qsys_system_nios2_qsys_0_oci_dct_packer.sv
// Directed bench for the DCT packer with a queue-based frame model.
// Every negedge compares all outputs to the model.
module tb_qsys_system_nios2_qsys_0_oci_dct_packer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;
  bit   chk_en;

  qsys_system_nios2_qsys_0_oci_dct_packer_if bus_if();

  qsys_system_nios2_qsys_0_oci_dct_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] m_q[$];
  bit m_held;
  bit m_ended;
  bit m_ending;

  function automatic logic [29:0] m_buf();
    logic [29:0] b;
    b = '0;
    foreach (m_q[i]) b = (b << 2) | {28'd0, m_q[i]};
    return b;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: a frame is the list of atoms taken since the last hand-off.
  initial begin
    m_held = 0; m_ended = 0; m_ending = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_held = 0; m_ended = 0; m_ending = 0;
      end else if (m_held) begin
        if (bus_if.frame_ready) begin
          m_q.delete();
          m_held = 0;
          if (m_ending || bus_if.end_req) m_ended = 1;
        end
        if (bus_if.end_req) m_ending = 1;
      end else if (!m_ended) begin
        if (bus_if.atom_valid) m_q.push_back(bus_if.atom);
        if (m_q.size() == 15)
          m_held = 1;
        else if ((bus_if.flush || bus_if.end_req) && m_q.size() > 0)
          m_held = 1;
        else if (bus_if.end_req)
          m_ended = 1;
        if (bus_if.end_req) m_ending = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("atom_ready", {31'd0, bus_if.atom_ready},
          {31'd0, !m_held && !m_ended});
      chk("frame_valid", {31'd0, bus_if.frame_valid},
          {31'd0, m_held});
      chk("dct_count", {28'd0, bus_if.dct_count},
          m_q.size());
      chk("dct_buffer", {2'd0, bus_if.dct_buffer},
          {2'd0, m_buf()});
      chk("test_ending", {31'd0, bus_if.test_ending},
          {31'd0, m_ending});
      chk("test_has_ended", {31'd0, bus_if.test_has_ended},
          {31'd0, m_ended});
      if (bus_if.frame_valid)
        chk("fv_nonzero", {31'd0, bus_if.dct_count != 4'd0}, 32'd1);
    end
  end

  task automatic step(input logic av, input logic [1:0] a,
                      input logic fl, input logic er,
                      input logic fr);
    bus_if.atom_valid  = av;
    bus_if.atom        = a;
    bus_if.flush       = fl;
    bus_if.end_req     = er;
    bus_if.frame_ready = fr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
  endtask

  task automatic fill15(input logic [1:0] a);
    for (int i = 0; i < 15; i++) step(1'b1, a, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; chk_en = 0;
    reset = 1'b1;
    bus_if.atom_valid = 0; bus_if.atom = 0;
    bus_if.flush = 0; bus_if.end_req = 0;
    bus_if.frame_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1;

    chk("rst_count", {28'd0, bus_if.dct_count}, 32'd0);
    chk("rst_ready", {31'd0, bus_if.atom_ready}, 32'd1);
    chk("rst_fv", {31'd0, bus_if.frame_valid}, 32'd0);

    fill15(2'b01);
    chk("fill_fv", {31'd0, bus_if.frame_valid}, 32'd1);
    chk("fill_cnt", {28'd0, bus_if.dct_count}, 32'd15);
    chk("fill_buf", {2'd0, bus_if.dct_buffer}, 32'h15555555);
    step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("hold_ready", {31'd0, bus_if.atom_ready}, 32'd0);
    chk("hold_buf", {2'd0, bus_if.dct_buffer}, 32'h15555555);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("drain_cnt", {28'd0, bus_if.dct_count}, 32'd0);
    chk("drain_ready", {31'd0, bus_if.atom_ready}, 32'd1);

    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("part_cnt", {28'd0, bus_if.dct_count}, 32'd3);
    chk("part_buf", {2'd0, bus_if.dct_buffer}, 32'h39);
    chk("part_fv", {31'd0, bus_if.frame_valid}, 32'd1);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("empty_flush_fv", {31'd0, bus_if.frame_valid}, 32'd0);
    idle();

    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    chk("sim_cnt", {28'd0, bus_if.dct_count}, 32'd5);
    chk("sim_buf", {2'd0, bus_if.dct_buffer}, 32'h63);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    fill15(2'b10);
    chk("rh_buf", {2'd0, bus_if.dct_buffer}, 32'h2AAAAAAA);
    do_reset();
    chk("rh_fv", {31'd0, bus_if.frame_valid}, 32'd0);
    chk("rh_cnt", {28'd0, bus_if.dct_count}, 32'd0);
    chk("rh_ready", {31'd0, bus_if.atom_ready}, 32'd1);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("rh_resume", {2'd0, bus_if.dct_buffer}, 32'h5);
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

    fill15(2'b11);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("eh_ending", {31'd0, bus_if.test_ending}, 32'd1);
    chk("eh_ended0", {31'd0, bus_if.test_has_ended}, 32'd0);
    idle();
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("eh_ready", {31'd0, bus_if.atom_ready}, 32'd0);
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    chk("eh_ended1", {31'd0, bus_if.test_has_ended}, 32'd1);
    repeat (3) step(1'b1, 2'd1, 1'b1, 1'b1, 1'b1);
    chk("eh_stay", {31'd0, bus_if.test_has_ended}, 32'd1);
    chk("eh_ready2", {31'd0, bus_if.atom_ready}, 32'd0);

    do_reset();
    chk("ee_rst", {31'd0, bus_if.test_ending}, 32'd0);
    step(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    chk("ee_ended", {31'd0, bus_if.test_has_ended}, 32'd1);
    chk("ee_fv", {31'd0, bus_if.frame_valid}, 32'd0);
    step(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("ee_cnt", {28'd0, bus_if.dct_count}, 32'd0);

    do_reset();
    step(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    chk("ef_cnt", {28'd0, bus_if.dct_count}, 32'd3);
    chk("ef_buf", {2'd0, bus_if.dct_buffer}, 32'h1B);
    chk("ef_ended0", {31'd0, bus_if.test_has_ended}, 32'd0);
    idle();
    step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("ef_ended1", {31'd0, bus_if.test_has_ended}, 32'd1);
    idle();
    idle();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
